// File: rtl/lfsr_prpg.sv
// Pseudo-random pattern generator for BIST-per-scan: Fibonacci LFSR feeding CHANNELS scan inputs,
// with a shift/capture sequencer that issues a programmed number of patterns.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | waiting for start; reseeding allowed
// ST_SHIFT   | delivering SHIFT_LEN scan bits per pattern, LFSR advancing
// ST_CAPTURE | one-cycle capture strobe, then next pattern or finish
module lfsr_prpg #(
  parameter int                WIDTH     = 16,
  parameter logic [WIDTH-1:0]  TAPS      = 16'hD008,
  parameter logic [WIDTH-1:0]  SEED      = 16'hACE1,
  parameter int                CHANNELS  = 4,
  parameter int                SHIFT_LEN = 32,
  parameter int                PCNT_W    = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [PCNT_W-1:0]   num_patterns,
  input  logic                hold,
  input  logic                seed_load,
  input  logic [WIDTH-1:0]    seed_value,
  output logic [CHANNELS-1:0] scan_bits,
  output logic                scan_enable,
  output logic                capture,
  output logic                busy,
  output logic                done,
  output logic                seed_err,
  output logic [PCNT_W-1:0]   pattern_count
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SHIFT   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  localparam int SCNT_W  = (SHIFT_LEN > 1) ? $clog2(SHIFT_LEN) : 1;
  localparam int SPACING = WIDTH / CHANNELS;
  localparam logic [SCNT_W-1:0] SHIFT_LAST = SCNT_W'(SHIFT_LEN - 1);

  logic [1:0]        state_q;
  logic [WIDTH-1:0]  lfsr_q;
  logic [WIDTH-1:0]  lfsr_next;
  logic [SCNT_W-1:0] shift_cnt_q;
  logic [PCNT_W-1:0] num_lat_q;
  logic [PCNT_W-1:0] pattern_count_q;
  logic [PCNT_W-1:0] pcount_inc;
  logic              done_q;
  logic              seed_err_q;

  assign lfsr_next  = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
  assign pcount_inc = pattern_count_q + PCNT_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      lfsr_q          <= SEED;
      shift_cnt_q     <= '0;
      num_lat_q       <= '0;
      pattern_count_q <= '0;
      done_q          <= 1'b0;
      seed_err_q      <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      seed_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A zero seed would lock the LFSR up, so it is refused and flagged.
          if (seed_load) begin
            if (seed_value != '0) lfsr_q <= seed_value;
            else                  seed_err_q <= 1'b1;
          end
          if (start) begin
            pattern_count_q <= '0;
            if (num_patterns == '0) begin
              done_q <= 1'b1;
            end else begin
              num_lat_q   <= num_patterns;
              shift_cnt_q <= '0;
              state_q     <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          if (!hold) begin
            lfsr_q <= lfsr_next;
            if (shift_cnt_q == SHIFT_LAST) state_q <= ST_CAPTURE;
            else                           shift_cnt_q <= shift_cnt_q + SCNT_W'(1);
          end
        end
        ST_CAPTURE: begin
          if (!hold) begin
            pattern_count_q <= pcount_inc;
            if (pcount_inc == num_lat_q) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end else begin
              shift_cnt_q <= '0;
              state_q     <= ST_SHIFT;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    assign scan_bits[k] = lfsr_q[WIDTH-1-k*SPACING];
  end

  assign scan_enable   = (state_q == ST_SHIFT) && !hold;
  assign capture       = (state_q == ST_CAPTURE) && !hold;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign seed_err      = seed_err_q;
  assign pattern_count = pattern_count_q;

endmodule

// File: tb/tb_lfsr_prpg.sv
// Directed bench for lfsr_prpg: reset values, single/multi-pattern runs with hold,
// reseeding, busy-time input rejection, zero-pattern runs, mid-run reset and full LFSR period.
module tb_lfsr_prpg;

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] num_patterns;
  logic        hold;
  logic        seed_load;
  logic [15:0] seed_value;
  logic [3:0]  scan_bits;
  logic        scan_enable;
  logic        capture;
  logic        busy;
  logic        done;
  logic        seed_err;
  logic [15:0] pattern_count;

  int pass_cnt  = 0;
  int check_cnt = 0;

  logic [15:0] model_state;
  int r_busy, r_se, r_cap, r_done, r_first_cap, r_done_idx;
  int r_hold_viol, r_bits_mis, r_seed_err, r_zero;
  bit r_timeout;
  logic [15:0] r_st [3];
  logic [15:0] r_st_wrap;

  lfsr_prpg dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .num_patterns  (num_patterns),
    .hold          (hold),
    .seed_load     (seed_load),
    .seed_value    (seed_value),
    .scan_bits     (scan_bits),
    .scan_enable   (scan_enable),
    .capture       (capture),
    .busy          (busy),
    .done          (done),
    .seed_err      (seed_err),
    .pattern_count (pattern_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // x^16+x^15+x^13+x^4+1 in left-shifting Fibonacci form: taps at bits 15,14,12,3.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
  endfunction

  function automatic logic [3:0] exp_bits(input logic [15:0] s);
    return {s[3], s[7], s[11], s[15]};
  endfunction

  // Runs the sequencer from the cycle after an accepted start until done (or timeout),
  // applying hold in two windows and optionally injecting start/seed_load at cycle inj.
  task automatic run_collect(input int max_cycles, input int h0, input int l0,
                             input int h1, input int l1, input int inj);
    int se_seen;
    bit fin;
    se_seen = 0; fin = 0;
    r_busy = 0; r_se = 0; r_cap = 0; r_done = 0; r_first_cap = 0; r_done_idx = 0;
    r_hold_viol = 0; r_bits_mis = 0; r_seed_err = 0; r_zero = 0;
    r_st[0] = 16'h0; r_st[1] = 16'h0; r_st[2] = 16'h0; r_st_wrap = 16'h0;
    for (int c = 1; c <= max_cycles && !fin; c++) begin
      hold = ((c >= h0) && (c < h0 + l0)) || ((c >= h1) && (c < h1 + l1));
      if (c == inj) begin
        start = 1'b1; seed_load = 1'b1; seed_value = 16'h1234; num_patterns = 16'd7;
      end
      @(negedge clock);
      if (busy) r_busy++;
      if (capture) begin
        r_cap++;
        if (r_first_cap == 0) r_first_cap = c;
      end
      if (seed_err) r_seed_err++;
      if (hold && (scan_enable || capture)) r_hold_viol++;
      if (dut.lfsr_q == 16'h0) r_zero++;
      if (scan_bits !== exp_bits(model_state)) r_bits_mis++;
      if (scan_enable) begin
        if (se_seen < 3) r_st[se_seen] = dut.lfsr_q;
        if (se_seen == 65535) r_st_wrap = dut.lfsr_q;
        se_seen++;
        r_se++;
        model_state = lfsr_step(model_state);
      end
      if (done) begin
        r_done++; r_done_idx = c; fin = 1;
      end
      @(posedge clock); #1;
      hold = 1'b0; start = 1'b0; seed_load = 1'b0;
    end
    r_timeout = !fin;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    check_cnt++; if (dut.lfsr_q !== 16'hACE1) $display("FAIL reset_state: got %h want ACE1", dut.lfsr_q); else pass_cnt++;
    check_cnt++; if (scan_bits !== 4'b0111) $display("FAIL reset_scan_bits: got %b want 0111", scan_bits); else pass_cnt++;
    check_cnt++;
    if ({scan_enable, capture, busy, done, seed_err} !== 5'b0)
      $display("FAIL reset_ctrl: got se=%b cap=%b busy=%b done=%b serr=%b want all 0",
               scan_enable, capture, busy, done, seed_err);
    else pass_cnt++;
    check_cnt++; if (pattern_count !== 16'd0) $display("FAIL reset_pcount: got %0d want 0", pattern_count); else pass_cnt++;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check_cnt++;
    if (busy !== 1'b0 || scan_bits !== 4'b0111)
      $display("FAIL idle_after_reset: got busy=%b bits=%b want 0/0111", busy, scan_bits);
    else pass_cnt++;
    @(posedge clock); #1;
    model_state = 16'hACE1;
  endtask

  task automatic test_single_pattern();
    num_patterns = 16'd1; start = 1'b1;
    @(negedge clock);
    check_cnt++; if (busy !== 1'b0) $display("FAIL start_cycle_busy: got %b want 0", busy); else pass_cnt++;
    @(posedge clock); #1;
    start = 1'b0;
    run_collect(100, 0, 0, 0, 0, 0);
    check_cnt++; if (r_timeout) $display("FAIL single_timeout: no done within 100 cycles"); else pass_cnt++;
    check_cnt++; if (r_busy != 33) $display("FAIL single_busy: got %0d want 33", r_busy); else pass_cnt++;
    check_cnt++; if (r_se != 32) $display("FAIL single_scan_en: got %0d want 32", r_se); else pass_cnt++;
    check_cnt++;
    if (r_st[0] !== 16'hACE1 || r_st[1] !== 16'h59C3 || r_st[2] !== 16'hB386)
      $display("FAIL single_seq: got %h %h %h want ACE1 59C3 B386", r_st[0], r_st[1], r_st[2]);
    else pass_cnt++;
    check_cnt++;
    if (r_cap != 1 || r_first_cap != 33)
      $display("FAIL single_capture: got count=%0d at=%0d want 1 at 33", r_cap, r_first_cap);
    else pass_cnt++;
    check_cnt++;
    if (r_done != 1 || r_done_idx != 34)
      $display("FAIL single_done: got count=%0d at=%0d want 1 at 34", r_done, r_done_idx);
    else pass_cnt++;
    check_cnt++; if (pattern_count !== 16'd1) $display("FAIL single_pcount: got %0d want 1", pattern_count); else pass_cnt++;
    check_cnt++; if (r_bits_mis != 0) $display("FAIL single_scan_bits: %0d cycles differ from model, want 0", r_bits_mis); else pass_cnt++;
  endtask

  task automatic test_hold();
    num_patterns = 16'd3; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    run_collect(300, 10, 5, 38, 2, 0);
    check_cnt++; if (r_busy != 106) $display("FAIL hold_busy: got %0d want 106", r_busy); else pass_cnt++;
    check_cnt++; if (r_se != 96) $display("FAIL hold_scan_en: got %0d want 96", r_se); else pass_cnt++;
    check_cnt++; if (r_cap != 3) $display("FAIL hold_capture: got %0d want 3", r_cap); else pass_cnt++;
    check_cnt++; if (r_first_cap != 40) $display("FAIL hold_first_capture: got cycle %0d want 40", r_first_cap); else pass_cnt++;
    check_cnt++;
    if (r_done != 1 || r_done_idx != 107)
      $display("FAIL hold_done: got count=%0d at=%0d want 1 at 107", r_done, r_done_idx);
    else pass_cnt++;
    check_cnt++; if (r_hold_viol != 0) $display("FAIL hold_outputs: %0d held cycles with strobe, want 0", r_hold_viol); else pass_cnt++;
    check_cnt++; if (r_bits_mis != 0) $display("FAIL hold_scan_bits: %0d cycles differ from model, want 0", r_bits_mis); else pass_cnt++;
    check_cnt++; if (pattern_count !== 16'd3) $display("FAIL hold_pcount: got %0d want 3", pattern_count); else pass_cnt++;
  endtask

  task automatic test_seed();
    seed_load = 1'b1; seed_value = 16'h0001;
    @(posedge clock); #1;
    seed_load = 1'b0;
    @(negedge clock);
    check_cnt++;
    if (dut.lfsr_q !== 16'h0001 || scan_bits !== 4'b0000)
      $display("FAIL seed_load: got state=%h bits=%b want 0001/0000", dut.lfsr_q, scan_bits);
    else pass_cnt++;
    check_cnt++; if (seed_err !== 1'b0) $display("FAIL seed_ok_err: got %b want 0", seed_err); else pass_cnt++;
    @(posedge clock); #1;
    model_state = 16'h0001;
    num_patterns = 16'd1; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    run_collect(100, 0, 0, 0, 0, 0);
    check_cnt++;
    if (r_st[0] !== 16'h0001 || r_st[1] !== 16'h0002)
      $display("FAIL seed_first_shift: got %h %h want 0001 0002", r_st[0], r_st[1]);
    else pass_cnt++;
    check_cnt++; if (r_bits_mis != 0 || r_busy != 33) $display("FAIL seed_run: got mis=%0d busy=%0d want 0/33", r_bits_mis, r_busy); else pass_cnt++;

    seed_load = 1'b1; seed_value = 16'h0000;
    @(negedge clock);
    check_cnt++; if (seed_err !== 1'b0) $display("FAIL zero_seed_early: got %b want 0", seed_err); else pass_cnt++;
    @(posedge clock); #1;
    seed_load = 1'b0;
    @(negedge clock);
    check_cnt++; if (seed_err !== 1'b1) $display("FAIL zero_seed_err: got %b want 1", seed_err); else pass_cnt++;
    check_cnt++; if (dut.lfsr_q !== model_state) $display("FAIL zero_seed_state: got %h want %h", dut.lfsr_q, model_state); else pass_cnt++;
    @(posedge clock); #1;
    @(negedge clock);
    check_cnt++; if (seed_err !== 1'b0) $display("FAIL zero_seed_pulse: got %b want 0", seed_err); else pass_cnt++;
    @(posedge clock); #1;

    seed_load = 1'b1; seed_value = 16'h8000; num_patterns = 16'd1; start = 1'b1;
    @(posedge clock); #1;
    seed_load = 1'b0; start = 1'b0;
    model_state = 16'h8000;
    run_collect(100, 0, 0, 0, 0, 0);
    check_cnt++;
    if (r_st[0] !== 16'h8000 || r_st[1] !== 16'h0001 || r_busy != 33)
      $display("FAIL seed_with_start: got %h %h busy=%0d want 8000 0001 33", r_st[0], r_st[1], r_busy);
    else pass_cnt++;
  endtask

  task automatic test_busy_ignore();
    num_patterns = 16'd2; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    num_patterns = 16'd9;
    run_collect(200, 0, 0, 0, 0, 5);
    check_cnt++; if (r_busy != 66) $display("FAIL busy_ignore_len: got %0d want 66", r_busy); else pass_cnt++;
    check_cnt++; if (pattern_count !== 16'd2) $display("FAIL busy_ignore_pcount: got %0d want 2", pattern_count); else pass_cnt++;
    check_cnt++; if (r_seed_err != 0) $display("FAIL busy_ignore_seed_err: got %0d pulses want 0", r_seed_err); else pass_cnt++;
    check_cnt++; if (r_bits_mis != 0) $display("FAIL busy_ignore_bits: %0d cycles differ from model, want 0", r_bits_mis); else pass_cnt++;
    @(negedge clock);
    check_cnt++; if (busy !== 1'b0) $display("FAIL busy_ignore_restart: got busy=%b want 0", busy); else pass_cnt++;
    @(posedge clock); #1;
  endtask

  task automatic test_zero_patterns();
    num_patterns = 16'd0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    run_collect(10, 0, 0, 0, 0, 0);
    check_cnt++; if (r_done != 1 || r_done_idx != 1) $display("FAIL zero_n_done: got count=%0d at=%0d want 1 at 1", r_done, r_done_idx); else pass_cnt++;
    check_cnt++;
    if (r_busy != 0 || r_se != 0 || r_cap != 0)
      $display("FAIL zero_n_activity: got busy=%0d se=%0d cap=%0d want 0", r_busy, r_se, r_cap);
    else pass_cnt++;
    check_cnt++; if (pattern_count !== 16'd0) $display("FAIL zero_n_pcount: got %0d want 0", pattern_count); else pass_cnt++;
    check_cnt++; if (dut.lfsr_q !== model_state) $display("FAIL zero_n_state: got %h want %h", dut.lfsr_q, model_state); else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    int dones;
    num_patterns = 16'd5; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check_cnt++;
    if (busy !== 1'b0 || dut.lfsr_q !== 16'hACE1 || done !== 1'b0 || scan_enable !== 1'b0)
      $display("FAIL mid_reset: got busy=%b state=%h done=%b se=%b want 0/ACE1/0/0", busy, dut.lfsr_q, done, scan_enable);
    else pass_cnt++;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done || busy) dones++;
    end
    check_cnt++; if (dones != 0) $display("FAIL mid_reset_quiet: got %0d active cycles want 0", dones); else pass_cnt++;
    @(posedge clock); #1;
    model_state = 16'hACE1;
  endtask

  task automatic test_period();
    num_patterns = 16'd2048; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    run_collect(70000, 0, 0, 0, 0, 0);
    check_cnt++; if (r_timeout) $display("FAIL period_timeout: no done within 70000 cycles"); else pass_cnt++;
    check_cnt++; if (r_st_wrap !== 16'hACE1) $display("FAIL period_wrap: got %h after 65535 advances want ACE1", r_st_wrap); else pass_cnt++;
    check_cnt++; if (r_zero != 0) $display("FAIL period_zero: got %0d zero-state cycles want 0", r_zero); else pass_cnt++;
    check_cnt++; if (r_se != 65536 || r_busy != 67584) $display("FAIL period_counts: got se=%0d busy=%0d want 65536/67584", r_se, r_busy); else pass_cnt++;
    check_cnt++; if (pattern_count !== 16'd2048) $display("FAIL period_pcount: got %0d want 2048", pattern_count); else pass_cnt++;
    check_cnt++; if (dut.lfsr_q !== 16'h59C3) $display("FAIL period_final: got %h want 59C3", dut.lfsr_q); else pass_cnt++;
    check_cnt++; if (r_bits_mis != 0) $display("FAIL period_bits: %0d cycles differ from model, want 0", r_bits_mis); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; num_patterns = 16'd0; hold = 1'b0;
    seed_load = 1'b0; seed_value = 16'h0; model_state = 16'hACE1;
    test_reset();
    test_single_pattern();
    test_hold();
    test_seed();
    test_busy_ignore();
    test_zero_patterns();
    test_reset_mid_run();
    test_period();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/lfsr_prpg.md
Name: lfsr_prpg

Overview:
Parametrised pseudo-random pattern generator for the BIST-per-scan flow. It is the successor to the single-channel 16-bit scan LFSR and adds:
- a configurable width and feedback polynomial
- multiple scan-channel outputs
- run-time reseeding
- a built-in shift/capture sequencer that issues a programmed number of scan patterns and signals completion.

It drives scan_enable and the scan-in bits of CHANNELS chains, feeding the DUT scan chains and the downstream signature compactor.

Parameters:
WIDTH, 16, LFSR length in bits (>= 4).
TAPS, 16'hD008, feedback mask: bit i set means state bit i is XORed into the feedback (default is x^16+x^15+x^13+x^4+1, maximal length).
SEED, 16'hACE1, reset state; must be non-zero.
CHANNELS, 4, number of scan-in outputs; 1 <= CHANNELS <= WIDTH.
SHIFT_LEN, 32, shift cycles per pattern (longest chain length, >= 1).
PCNT_W, 16, width of the pattern counters.

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request to begin a run; sampled in IDLE only
num_patterns  in  PCNT_W  number of patterns for the run; latched on an accepted start
hold  in  1  when high, freezes the sequencer and LFSR in SHIFT or CAPTURE
seed_load  in  1  loads seed_value into the LFSR; honoured in IDLE only
seed_value  in  WIDTH  new seed
scan_bits  out  CHANNELS  scan-in data; channel k = state[WIDTH-1-k*(WIDTH/CHANNELS)]
scan_enable  out  1  high while a shift bit is being delivered
capture  out  1  one-cycle capture strobe per pattern
busy  out  1  high in SHIFT or CAPTURE
done  out  1  one-cycle pulse when a run completes
seed_err  out  1  one-cycle pulse when a zero seed load is rejected
pattern_count  out  PCNT_W  patterns completed in the current or last run

Behaviour:
- LFSR (Fibonacci form)
  - Next state = {state[WIDTH-2:0], ^(state & TAPS)}.
  - XOR feedback, so all-zero is the lock-up state and must never be entered.
  - The LFSR advances only on a SHIFT cycle with hold=0; it holds in every other case.
- Reset
  - state=SEED, FSM=IDLE, counters=0.
  - scan_enable=capture=busy=done=seed_err=0.
  - Reset mid-run aborts immediately; done is not pulsed.
- scan_bits is combinational from state and is always driven, including in IDLE.
- FSM states: IDLE, SHIFT, CAPTURE.
- IDLE
  - seed_load=1 with seed_value != 0: state <= seed_value.
  - seed_load=1 with seed_value == 0: state is unchanged; seed_err pulses on the next cycle.
  - start=1 with num_patterns == 0: no SHIFT; done pulses on the next cycle; pattern_count <= 0.
  - start=1 with num_patterns != 0: latch num_patterns, pattern_count <= 0, shift counter <= 0, go to SHIFT.
  - seed_load and start in the same cycle: both are honoured, and the first pattern uses the new seed.
- SHIFT
  - scan_enable = ~hold.
  - Each non-held cycle: the LFSR advances and the shift counter increments.
  - After SHIFT_LEN non-held cycles: go to CAPTURE.
  - The first SHIFT cycle presents the pre-advance state, i.e. the seed on the first pattern.
- CAPTURE
  - scan_enable=0; capture = ~hold; the LFSR holds.
  - On a non-held cycle: pattern_count increments.
  - If the incremented count equals the latched num_patterns: go to IDLE and pulse done on the following cycle. Otherwise: reset the shift counter and return to SHIFT.
- Latency per pattern is SHIFT_LEN+1 cycles with no hold. A run of N patterns has busy high for N*(SHIFT_LEN+1) cycles.
- Inputs while busy:
  - start and seed_load are ignored while busy, and no seed_err is raised.
  - num_patterns changes while busy have no effect.
- Between runs: the LFSR continues from its last state on the next run unless reseeded (no implicit re-seed).
- pattern_count holds its final value in IDLE until the next accepted start.
- hold: outputs capture and scan_enable are forced 0 while held; all state is frozen.

Test Plan:
- Reset → state 0xACE1; scan_bits=4'b0111 (bit0=state[15]=1, bit1=state[11]=1, bit2=state[7]=1, bit3=state[3]=0); all control outputs 0.
- start with num_patterns=1 → busy for exactly 33 cycles. SHIFT cycles 1..32 have scan_enable=1. The state sequence begins 0xACE1, 0x59C3, 0xB386. Cycle 33 has capture=1. done pulses once and pattern_count=1.
- num_patterns=3 with hold asserted for 5 cycles mid-SHIFT and 2 cycles during CAPTURE → busy for 3*33+7=106 cycles. scan_enable=0 and capture=0 while held. Totals are exactly 96 scan_enable cycles, 3 capture pulses and 1 done.
- seed_load with 0x0001 in IDLE, then start (N=1) → first shifted state is 0x0001, next is 0x0002. seed_load with 0x0000 → seed_err pulses for 1 cycle and state is unchanged. seed_load or start during busy → ignored.
- start with num_patterns=0 → done pulses on the next cycle; busy, scan_enable and capture never assert.
- Period check: 65535 LFSR advances from 0xACE1 (2048 patterns of SHIFT_LEN=32 minus one shift, or a direct advance count) → state returns to 0xACE1 and never reaches 0. Reset asserted mid-SHIFT → IDLE and SEED on the next cycle with no done.
